// File: rtl/intc_pkg.sv
// Shared definitions for the wb_intctrl interrupt controller.
// Register word offsets, default code width and bus state type.
package intc_pkg;

  localparam int INTC_CODE_W = 4;

  localparam logic [2:0] INTC_PENDING = 3'd0;
  localparam logic [2:0] INTC_MASK    = 3'd1;
  localparam logic [2:0] INTC_ACTIVE  = 3'd2;
  localparam logic [2:0] INTC_MODE    = 3'd3;
  localparam logic [2:0] INTC_SWSET   = 3'd4;

  typedef enum logic {
    WB_IDLE,
    WB_ACK
  } wb_state_e;

endpackage

// File: rtl/wb_intctrl_if.sv
// Wishbone classic register-access bundle for wb_intctrl.
// dat_i carries write data to the slave, dat_o read data back.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_i,
    input  dat_o, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_i,
    output dat_o, ack
  );
endinterface

// File: rtl/wb_intctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, code = index+1.
// All-zero input yields code 0.
module intc_prio_enc #(
  parameter int NSRC   = 8,
  parameter int CODE_W = 4
) (
  input  logic [NSRC-1:0]   req_i,
  output logic [CODE_W-1:0] code_o
);

  always_comb begin
    code_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) code_o = CODE_W'(i + 1);
    end
  end

endmodule

// File: rtl/wb_intctrl.sv
// Wishbone interrupt controller: pending latches, mask, priority, cpu code.
// Define INTC_EDGE_EN to add the per-source MODE (edge/level) register.
module wb_intctrl
  import intc_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int CODE_W = INTC_CODE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.slave               bus,
  input  logic [NSRC-1:0]   src,
  input  logic              enabled,
  output logic [CODE_W-1:0] cpu_exception,
  output logic              irq
);

  if (NSRC < 1 || NSRC > (2 ** CODE_W) - 1 || NSRC > 32) begin : g_bad_nsrc
    $error("wb_intctrl: NSRC does not fit CODE_W or the 32-bit registers");
  end

  wb_state_e st_q, st_d;

  logic [31:0]       dat_q, dat_d, rdata;
  logic [NSRC-1:0]   src_q, hw_q, hw_d, sw_q, sw_d;
  logic [NSRC-1:0]   mask_q, mask_d, mode_q;
  logic [NSRC-1:0]   wdat, clr, set, pend, masked;
  logic [CODE_W-1:0] code_q, code_d, enc;
  logic              irq_q, irq_d;
  logic              acc, wr;
  logic [2:0]        off;
  logic              unused_bus;

  assign off        = bus.adr[4:2];
  assign wdat       = bus.dat_i[NSRC-1:0];
  assign unused_bus = &{1'b0, bus.adr[31:5], bus.adr[1:0], bus.dat_i};

  always_comb begin
    st_d = WB_IDLE;
    acc  = 1'b0;
    unique case (st_q)
      WB_IDLE: begin
        if (bus.cyc && bus.stb) begin
          st_d = WB_ACK;
          acc  = 1'b1;
        end
      end
      WB_ACK:  st_d = WB_IDLE;
      default: st_d = WB_IDLE;
    endcase
  end

  assign wr  = acc && bus.we;
  assign clr = (wr && off == INTC_PENDING) ? wdat : '0;
  assign set = (wr && off == INTC_SWSET) ? wdat : '0;

  assign pend   = hw_q | sw_q;
  assign masked = pend & mask_q;

  always_comb begin
    rdata = '0;
    unique case (off)
      INTC_PENDING: rdata = 32'(pend);
      INTC_MASK:    rdata = 32'(mask_q);
      INTC_ACTIVE:  rdata = 32'(code_q);
      INTC_MODE:    rdata = 32'(mode_q);
      default:      rdata = '0;
    endcase
  end

  // Set wins over W1C: the OR is applied after the clear.
  assign sw_d   = (sw_q & ~clr) | set;
  assign mask_d = (wr && off == INTC_MASK) ? wdat : mask_q;
  assign dat_d  = (acc && !bus.we) ? rdata : '0;

`ifdef INTC_EDGE_EN
  logic [NSRC-1:0] prev_q, mode_d, rise;

  assign rise   = src_q & ~prev_q;
  assign mode_d = (wr && off == INTC_MODE) ? wdat : mode_q;
  assign hw_d   = (mode_q & ((hw_q & ~clr) | rise))
                | (~mode_q & src_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      mode_q <= '0;
    end else begin
      prev_q <= src_q;
      mode_q <= mode_d;
    end
  end
`else
  assign mode_q = '0;
  assign hw_d   = src_q;
`endif

  intc_prio_enc #(
    .NSRC   (NSRC),
    .CODE_W (CODE_W)
  ) u_enc (
    .req_i  (masked),
    .code_o (enc)
  );

  assign code_d = enabled ? enc : '0;
  assign irq_d  = |code_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= WB_IDLE;
      dat_q  <= '0;
      src_q  <= '0;
      hw_q   <= '0;
      sw_q   <= '0;
      mask_q <= '0;
      code_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      dat_q  <= dat_d;
      src_q  <= src;
      hw_q   <= hw_d;
      sw_q   <= sw_d;
      mask_q <= mask_d;
      code_q <= code_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.ack       = (st_q == WB_ACK);
  assign bus.dat_o     = dat_q;
  assign cpu_exception = code_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_wb_intctrl.sv
// Self-checking bench for wb_intctrl: directed steps plus random traffic.
// Edge-mode steps are compiled in when INTC_EDGE_EN is defined.
module tb_wb_intctrl;
  import intc_pkg::*;

  localparam int NSRC   = 8;
  localparam int CODE_W = 4;

  logic              clk     = 1'b0;
  logic              rst_i   = 1'b1;
  logic              enabled = 1'b0;
  logic [NSRC-1:0]   src     = '0;
  logic [CODE_W-1:0] cpu_exception;
  logic              irq;

  if_wb bus ();

  int checks   = 0;
  int failures = 0;

  wb_intctrl #(
    .NSRC   (NSRC),
    .CODE_W (CODE_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .bus           (bus),
    .src           (src),
    .enabled       (enabled),
    .cpu_exception (cpu_exception),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Architectural view of the controller, advanced once per clock edge.
  logic [NSRC-1:0]   m_mask = '0, m_sw = '0, m_hw = '0, m_mode = '0;
  logic [NSRC-1:0]   m_s1 = '0, m_s2 = '0;
  logic [CODE_W-1:0] m_code = '0;
  logic              m_ack = 1'b0;

  function automatic logic [CODE_W-1:0] prio(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++)
      if (v[i]) return CODE_W'(i + 1);
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NSRC-1:0]   s, rise, clr, set, wd, pend;
    logic              acc, w;
    logic [2:0]        a;
    logic [31:0]       rd, edat;
    logic [CODE_W-1:0] ecode;
    s    = src;
    a    = bus.adr[4:2];
    w    = bus.we;
    wd   = bus.dat_i[NSRC-1:0];
    acc  = !rst_i && bus.cyc && bus.stb && !m_ack;
    pend = m_hw | m_sw;
    case (a)
      INTC_PENDING: rd = 32'(pend);
      INTC_MASK:    rd = 32'(m_mask);
      INTC_ACTIVE:  rd = 32'(m_code);
      INTC_MODE:    rd = 32'(m_mode);
      default:      rd = '0;
    endcase
    ecode = (!rst_i && enabled) ? prio(pend & m_mask) : '0;
    edat  = (acc && !w) ? rd : '0;
    if (rst_i) begin
      m_mask = '0; m_sw = '0; m_hw = '0; m_mode = '0;
      m_s1   = '0; m_s2 = '0;
    end else begin
      clr  = (acc && w && a == INTC_PENDING) ? wd : '0;
      set  = (acc && w && a == INTC_SWSET) ? wd : '0;
      rise = m_s1 & ~m_s2;
      for (int i = 0; i < NSRC; i++)
        m_hw[i] = m_mode[i] ? ((m_hw[i] & ~clr[i]) | rise[i]) : m_s1[i];
      m_sw = (m_sw & ~clr) | set;
      if (acc && w && a == INTC_MASK) m_mask = wd;
`ifdef INTC_EDGE_EN
      if (acc && w && a == INTC_MODE) m_mode = wd;
`endif
      m_s2 = m_s1;
      m_s1 = s;
    end
    m_code = ecode;
    m_ack  = acc;
    @(posedge clk);
    #1;
    chk("code", 32'(cpu_exception), 32'(ecode));
    chk("irq", 32'(irq), 32'(ecode != '0));
    chk("ack", 32'(bus.ack), 32'(acc));
    chk("dat_o", bus.dat_o, edat);
  endtask

  task automatic idle_bus();
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = 1'b1;
    bus.adr   = {27'd0, off, 2'b00};
    bus.dat_i = d;
    step();
    idle_bus();
    step();
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    bus.adr = {27'd0, off, 2'b00};
    step();
    d = bus.dat_o;
    idle_bus();
    step();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] rv;
    idle_bus();
    bus.adr   = '0;
    bus.dat_i = '0;

    // Reset
    rst_i = 1'b1;
    steps(2);
    chk("rst_code", 32'(cpu_exception), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_i = 1'b0;
    bus_read(INTC_PENDING, rv); chk("rst_pending", rv, 32'd0);
    bus_read(INTC_MASK, rv);    chk("rst_mask", rv, 32'd0);
    bus_read(INTC_MODE, rv);    chk("rst_mode", rv, 32'd0);

    // Level source
    bus_write(INTC_MASK, 32'h05);
    enabled = 1'b1;
    src     = 8'h04;
    steps(2);
    chk("lvl_not_yet", 32'(cpu_exception), 32'd0);
    step();
    chk("lvl_code3", 32'(cpu_exception), 32'd3);
    src = 8'h00;
    steps(3);
    chk("lvl_off", 32'(cpu_exception), 32'd0);

    // Priority and enable gating
    bus_write(INTC_MASK, 32'hFF);
    src = 8'h06;
    steps(3);
    chk("prio_code2", 32'(cpu_exception), 32'd2);
    src = 8'h04;
    steps(3);
    chk("prio_code3", 32'(cpu_exception), 32'd3);
    enabled = 1'b0;
    step();
    chk("dis_code", 32'(cpu_exception), 32'd0);
    chk("dis_irq", 32'(irq), 32'd0);
    enabled = 1'b1;
    src     = 8'h00;
    steps(3);

`ifdef INTC_EDGE_EN
    // Edge-latched source
    bus_write(INTC_MODE, 32'h01);
    bus_write(INTC_MASK, 32'h01);
    src = 8'h01;
    step();
    src = 8'h00;
    steps(4);
    bus_read(INTC_PENDING, rv); chk("edge_pend", rv, 32'h01);
    chk("edge_code", 32'(cpu_exception), 32'd1);
    bus_write(INTC_PENDING, 32'h01);
    bus_read(INTC_PENDING, rv); chk("edge_w1c", rv, 32'h00);
    src = 8'h01;
    step();
    src = 8'h00;
    bus_write(INTC_PENDING, 32'h01);
    bus_read(INTC_PENDING, rv); chk("edge_set_wins", rv, 32'h01);
    bus_write(INTC_PENDING, 32'h01);
    bus_write(INTC_MODE, 32'h00);
`else
    bus_write(INTC_MODE, 32'hFF);
    bus_read(INTC_MODE, rv); chk("mode_ro0", rv, 32'd0);
`endif

    // Soft pending
    bus_write(INTC_MASK, 32'h80);
    steps(3);
    bus_write(INTC_SWSET, 32'h80);
    step();
    chk("sw_code8", 32'(cpu_exception), 32'd8);
    bus_read(INTC_ACTIVE, rv); chk("sw_active", rv, 32'd8);
    bus_write(INTC_PENDING, 32'h80);
    step();
    chk("sw_clr", 32'(cpu_exception), 32'd0);

    // Bus corner cases
    bus_read(3'd6, rv); chk("off6", rv, 32'd0);
    bus_write(INTC_SWSET, 32'hFFFF_FF00);
    bus_read(INTC_PENDING, rv); chk("swset_hi", rv, 32'd0);
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    bus.adr = {27'd0, INTC_MASK, 2'b00};
    steps(3);
    chk("held_ack", 32'(bus.ack), 32'd1);
    step();
    rst_i = 1'b1;
    step();
    chk("rst_mid_ack", 32'(bus.ack), 32'd0);
    rst_i = 1'b0;
    idle_bus();
    step();
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    rst_i   = 1'b1;
    step();
    chk("rst_req_ack", 32'(bus.ack), 32'd0);
    rst_i = 1'b0;
    idle_bus();
    step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      src     = NSRC'($urandom);
      enabled = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = $urandom_range(0, 1) == 1;
        bus.adr   = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
        bus.dat_i = $urandom;
      end else begin
        idle_bus();
      end
      if (n == 300) rst_i = 1'b1;
      step();
      rst_i = 1'b0;
    end
    idle_bus();
    steps(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
